// File: rtl/rf_issue_scheduler_if.sv
// Issue bundle between instruction decode and the register-file issue
// scheduler: four channels of valid/ready handshake plus operand addresses.
interface rf_issue_scheduler_if #(
   parameter int ADDRESS_WIDTH = 5
);
   logic [3:0]                    issue_valid_i;
   logic [3:0]                    issue_ready_o;
   logic [3:0][ADDRESS_WIDTH-1:0] issue_a_i;
   logic [3:0][ADDRESS_WIDTH-1:0] issue_b_i;
   logic [1:0][ADDRESS_WIDTH-1:0] issue_c_i;   // index 0 = ch2, index 1 = ch3
   logic [3:0][ADDRESS_WIDTH-1:0] issue_r_i;
   logic [3:0]                    issue_wr_i;

   // Decoder side.
   modport master (
      output issue_valid_i, issue_a_i, issue_b_i, issue_c_i, issue_r_i, issue_wr_i,
      input  issue_ready_o
   );

   // Scheduler side.
   modport slave (
      input  issue_valid_i, issue_a_i, issue_b_i, issue_c_i, issue_r_i, issue_wr_i,
      output issue_ready_o
   );
endinterface

// File: rtl/rf_issue_scheduler.sv
// Issue/write-back scheduler for a 4-write-port register file.
// Each channel runs IDLE -> EXEC(cnt) -> WB for its fixed latency; a busy
// scoreboard blocks RAW/WAW hazards, and ch0 > ch1 > ch2 > ch3 resolves
// same-cycle conflicts. Addresses 0..2 are special inputs and never tracked.
module rf_issue_scheduler #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int LAT0          = 1,
   parameter int LAT1          = 1,
   parameter int LAT2          = 2,
   parameter int LAT3          = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   rf_issue_scheduler_if.slave                issue,
   input  logic                               flush_i,
   output logic [3:0]                         wb_en_o,
   output logic [3:0][ADDRESS_WIDTH-1:0]      wb_sel_o,
   output logic [(2**ADDRESS_WIDTH)-1:0]      busy_o,
   output logic [3:0]                         illegal_dest_o,
   output logic                               idle_o
);

   localparam int                       UNITS     = 2**ADDRESS_WIDTH;
   localparam int                       CH        = 4;
   localparam logic [ADDRESS_WIDTH-1:0] FIRST_REG = ADDRESS_WIDTH'(3);
   // Initial EXEC count per channel; 0 means the op goes straight to WB.
   localparam logic [3:0]               LAT_M1 [CH] = '{4'(LAT0 - 1), 4'(LAT1 - 1),
                                                        4'(LAT2 - 1), 4'(LAT3 - 1)};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WB
   } state_e;

   state_e                   state_q [CH];
   state_e                   state_d [CH];
   logic [3:0]               cnt_q   [CH];
   logic [3:0]               cnt_d   [CH];
   logic [ADDRESS_WIDTH-1:0] dest_q  [CH];
   logic [ADDRESS_WIDTH-1:0] dest_d  [CH];
   logic [CH-1:0]            wr_q, wr_d;            // op really writes (dest >= 3)
   logic [UNITS-1:0]         busy_q, busy_d;
   logic [CH-1:0]            illegal_q, illegal_d;
   logic                     idle_q, idle_d;

   logic [CH-1:0]            ready_c;
   logic [CH-1:0]            accept_c;
   logic [CH-1:0]            wr_eff_c;

   // A tracked register whose result is still pending.
   function automatic logic reg_busy(input logic [ADDRESS_WIDTH-1:0] addr,
                                     input logic [UNITS-1:0]         busy);
      return (addr >= FIRST_REG) && busy[addr];
   endfunction

   // Readiness: scoreboard hazards plus conflicts with higher-priority accepts this cycle.
   always_comb begin
      logic                     hazard;
      logic                     has_c;
      logic [ADDRESS_WIDTH-1:0] src_a, src_b, src_c, dst;
      // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
      ready_c  = '0;
      accept_c = '0;
      wr_eff_c = '0;
      for (int n = 0; n < CH; n++) begin
         src_a       = issue.issue_a_i[n];
         src_b       = issue.issue_b_i[n];
         src_c       = (n == 2) ? issue.issue_c_i[0] : issue.issue_c_i[1];
         has_c       = (n >= 2);
         dst         = issue.issue_r_i[n];
         wr_eff_c[n] = issue.issue_wr_i[n] && (dst >= FIRST_REG);

         hazard = reg_busy(src_a, busy_q) || reg_busy(src_b, busy_q) ||
                  (has_c && reg_busy(src_c, busy_q)) ||
                  (wr_eff_c[n] && busy_q[dst]);

         for (int m = 0; m < n; m++) begin
            if (accept_c[m] && wr_eff_c[m]) begin
               if ((src_a == issue.issue_r_i[m]) || (src_b == issue.issue_r_i[m]) ||
                   (has_c && (src_c == issue.issue_r_i[m])) ||
                   (wr_eff_c[n] && (dst == issue.issue_r_i[m]))) begin
                  hazard = 1'b1;
               end
            end
         end

         ready_c[n]  = rst_ni && !flush_i && (state_q[n] != ST_EXEC) && !hazard;
         accept_c[n] = ready_c[n] && issue.issue_valid_i[n];
      end
   end

   assign issue.issue_ready_o = ready_c;

   // Next state of the channel FSMs, scoreboard, illegal-dest pulses and idle flag.
   always_comb begin
      logic all_idle;
      busy_d    = busy_q;
      illegal_d = '0;
      wr_d      = wr_q;
      for (int n = 0; n < CH; n++) begin
         state_d[n] = state_q[n];
         cnt_d[n]   = cnt_q[n];
         dest_d[n]  = dest_q[n];

         // The busy bit drops at the edge that ends the WB cycle.
         if ((state_q[n] == ST_WB) && wr_q[n]) begin
            busy_d[dest_q[n]] = 1'b0;
         end

         case (state_q[n])
            ST_EXEC: begin
               if (cnt_q[n] == 4'd1) begin
                  state_d[n] = ST_WB;
               end else begin
                  cnt_d[n] = cnt_q[n] - 4'd1;
               end
            end
            ST_WB:   state_d[n] = ST_IDLE;
            default: state_d[n] = ST_IDLE;
         endcase

         if (accept_c[n]) begin
            dest_d[n]    = issue.issue_r_i[n];
            wr_d[n]      = wr_eff_c[n];
            illegal_d[n] = issue.issue_wr_i[n] && !wr_eff_c[n];
            if (wr_eff_c[n]) begin
               busy_d[issue.issue_r_i[n]] = 1'b1;
            end
            if (LAT_M1[n] == 4'd0) begin
               state_d[n] = ST_WB;
            end else begin
               state_d[n] = ST_EXEC;
               cnt_d[n]   = LAT_M1[n];
            end
         end
      end

      // Flush aborts everything in flight; accepts are already suppressed by ready.
      if (flush_i) begin
         for (int n = 0; n < CH; n++) begin
            state_d[n] = ST_IDLE;
         end
         busy_d    = '0;
         illegal_d = '0;
      end

      all_idle = 1'b1;
      for (int n = 0; n < CH; n++) begin
         if (state_d[n] != ST_IDLE) begin
            all_idle = 1'b0;
         end
      end
      idle_d = all_idle && (busy_d == '0);
   end

   // Register state with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_ni) begin
         for (int n = 0; n < CH; n++) begin
            state_q[n] <= ST_IDLE;
            cnt_q[n]   <= '0;
            dest_q[n]  <= '0;
         end
         wr_q      <= '0;
         busy_q    <= '0;
         illegal_q <= '0;
         idle_q    <= 1'b1;
      end else begin
         for (int n = 0; n < CH; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
            dest_q[n]  <= dest_d[n];
         end
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         illegal_q <= illegal_d;
         idle_q    <= idle_d;
      end
   end

   // Write-back strobe: one cycle in WB, suppressed during flush or reset.
   always_comb begin
      wb_en_o  = '0;
      wb_sel_o = '0;
      for (int n = 0; n < CH; n++) begin
         if (rst_ni && !flush_i && (state_q[n] == ST_WB) && wr_q[n]) begin
            wb_en_o[n]  = 1'b1;
            wb_sel_o[n] = dest_q[n];
         end
      end
   end

   assign busy_o         = busy_q;
   assign illegal_dest_o = illegal_q;
   assign idle_o         = idle_q;

endmodule

// File: tb/tb_rf_issue_scheduler.sv
// Self-checking bench for rf_issue_scheduler: directed scenarios followed by
// randomized traffic, compared every cycle against a cycle-count reference model.
module tb_rf_issue_scheduler;

   localparam int AW    = 5;
   localparam int UNITS = 32;
   localparam int LAT [4] = '{1, 1, 2, 2};

   logic                clk = 1'b0;
   logic                rst_ni = 1'b0;
   logic                flush_i = 1'b0;
   logic [3:0]          wb_en;
   logic [3:0][AW-1:0]  wb_sel;
   logic [UNITS-1:0]    busy;
   logic [3:0]          illegal;
   logic                idle;

   rf_issue_scheduler_if #(.ADDRESS_WIDTH(AW)) issue_if ();

   rf_issue_scheduler #(
      .ADDRESS_WIDTH(AW), .LAT0(LAT[0]), .LAT1(LAT[1]), .LAT2(LAT[2]), .LAT3(LAT[3])
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .issue         (issue_if),
      .flush_i       (flush_i),
      .wb_en_o       (wb_en),
      .wb_sel_o      (wb_sel),
      .busy_o        (busy),
      .illegal_dest_o(illegal),
      .idle_o        (idle)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: each in-flight op is remembered by the cycle number of its write-back.
   bit              m_act   [4];
   int              m_wb_at [4];
   logic [AW-1:0]   m_dst   [4];
   bit              m_wr    [4];
   logic [UNITS-1:0] m_busy;
   logic [3:0]      m_ill;
   int              cyc;

   function automatic bit in_list(input logic [AW-1:0] x, input logic [AW-1:0] q[$]);
      foreach (q[i]) if (q[i] == x) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] model_ready();
      logic [3:0]    rdy;
      logic [AW-1:0] taken[$];
      logic [AW-1:0] srcs[$];
      logic [AW-1:0] r;
      bit            blocked, writes;
      rdy = '0;
      for (int n = 0; n < 4; n++) begin
         srcs.delete();
         srcs.push_back(issue_if.issue_a_i[n]);
         srcs.push_back(issue_if.issue_b_i[n]);
         if (n == 2) srcs.push_back(issue_if.issue_c_i[0]);
         if (n == 3) srcs.push_back(issue_if.issue_c_i[1]);
         r       = issue_if.issue_r_i[n];
         writes  = issue_if.issue_wr_i[n] && (r >= 3);
         blocked = !rst_ni || flush_i || (m_act[n] && (cyc < m_wb_at[n]));
         foreach (srcs[i]) begin
            if ((srcs[i] >= 3) && m_busy[srcs[i]]) blocked = 1'b1;
            if (in_list(srcs[i], taken)) blocked = 1'b1;
         end
         if (writes && (m_busy[r] || in_list(r, taken))) blocked = 1'b1;
         rdy[n] = !blocked;
         if (rdy[n] && issue_if.issue_valid_i[n] && writes) taken.push_back(r);
      end
      return rdy;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 4; n++) m_act[n] = 1'b0;
      m_busy = '0;
      m_ill  = '0;
   endtask

   task automatic model_update(input logic [3:0] acc);
      logic [AW-1:0] r;
      if (!rst_ni || flush_i) begin
         model_reset();
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (m_act[n] && (cyc == m_wb_at[n])) begin
               m_act[n] = 1'b0;
               if (m_wr[n]) m_busy[m_dst[n]] = 1'b0;
            end
         end
         m_ill = '0;
         for (int n = 0; n < 4; n++) begin
            if (acc[n]) begin
               r          = issue_if.issue_r_i[n];
               m_act[n]   = 1'b1;
               m_wb_at[n] = cyc + LAT[n];
               m_dst[n]   = r;
               m_wr[n]    = issue_if.issue_wr_i[n] && (r >= 3);
               m_ill[n]   = issue_if.issue_wr_i[n] && (r < 3);
               if (m_wr[n]) m_busy[r] = 1'b1;
            end
         end
      end
      cyc++;
   endtask

   // Compare every output for the current cycle, then advance one clock.
   task automatic tick();
      logic [3:0]         rdy, acc, exp_en;
      logic [3:0][AW-1:0] exp_sel;
      bit                 any_act;
      #2;
      rdy     = model_ready();
      acc     = rdy & issue_if.issue_valid_i;
      exp_en  = '0;
      exp_sel = '0;
      any_act = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (rst_ni && !flush_i && m_act[n] && (cyc == m_wb_at[n]) && m_wr[n]) begin
            exp_en[n]  = 1'b1;
            exp_sel[n] = m_dst[n];
         end
         if (m_act[n]) any_act = 1'b1;
      end
      check("issue_ready", 64'(issue_if.issue_ready_o), 64'(rdy));
      check("wb_en",       64'(wb_en),   64'(exp_en));
      check("wb_sel",      64'(wb_sel),  64'(exp_sel));
      check("busy",        64'(busy),    64'(m_busy));
      check("illegal",     64'(illegal), 64'(m_ill));
      check("idle",        64'(idle),    64'(!any_act && (m_busy == '0)));
      @(posedge clk);
      #1;
      model_update(acc);
   endtask

   task automatic clear_inputs();
      issue_if.issue_valid_i = '0;
      issue_if.issue_a_i     = '0;
      issue_if.issue_b_i     = '0;
      issue_if.issue_c_i     = '0;
      issue_if.issue_r_i     = '0;
      issue_if.issue_wr_i    = '0;
      flush_i                = 1'b0;
   endtask

   task automatic set_op(input int n, input int a, input int b, input int c,
                         input int r, input bit wr);
      issue_if.issue_valid_i[n] = 1'b1;
      issue_if.issue_a_i[n]     = AW'(a);
      issue_if.issue_b_i[n]     = AW'(b);
      issue_if.issue_r_i[n]     = AW'(r);
      issue_if.issue_wr_i[n]    = wr;
      if (n == 2) issue_if.issue_c_i[0] = AW'(c);
      if (n == 3) issue_if.issue_c_i[1] = AW'(c);
   endtask

   task automatic idle_cycles(input int k);
      clear_inputs();
      repeat (k) tick();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, UNITS - 1));
      return AW'($urandom_range(0, 10));
   endfunction

   initial begin
      cyc = 0;
      clear_inputs();
      rst_ni = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      tick();
      rst_ni = 1'b1;
      idle_cycles(1);

      // Single ch0 write to r5.
      set_op(0, 1, 2, 0, 5, 1'b1);
      tick();
      idle_cycles(3);

      // ch2 writes r7, ch0 reads r7 and waits for the scoreboard.
      set_op(2, 0, 1, 2, 7, 1'b1);
      tick();
      clear_inputs();
      set_op(0, 7, 0, 0, 8, 1'b1);
      repeat (3) tick();
      idle_cycles(3);

      // ch0 and ch1 both target r9.
      set_op(0, 0, 0, 0, 9, 1'b1);
      set_op(1, 0, 0, 0, 9, 1'b1);
      tick();
      issue_if.issue_valid_i[0] = 1'b0;
      repeat (3) tick();
      idle_cycles(3);

      // Illegal destination on ch1.
      set_op(1, 3, 4, 0, 2, 1'b1);
      tick();
      idle_cycles(3);

      // Flush with ch2/ch3 in flight.
      set_op(2, 0, 0, 0, 4, 1'b1);
      set_op(3, 0, 0, 0, 6, 1'b1);
      tick();
      clear_inputs();
      flush_i = 1'b1;
      tick();
      idle_cycles(4);

      // Reset while ch3 is in EXEC.
      set_op(3, 0, 0, 0, 10, 1'b1);
      tick();
      clear_inputs();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      idle_cycles(4);

      // Randomized traffic.
      repeat (3000) begin
         rst_ni  = ($urandom_range(0, 199) != 0);
         flush_i = ($urandom_range(0, 49) == 0);
         for (int n = 0; n < 4; n++) begin
            issue_if.issue_valid_i[n] = 1'($urandom_range(0, 1));
            issue_if.issue_a_i[n]     = rand_addr();
            issue_if.issue_b_i[n]     = rand_addr();
            issue_if.issue_r_i[n]     = rand_addr();
            issue_if.issue_wr_i[n]    = ($urandom_range(0, 3) != 0);
         end
         issue_if.issue_c_i[0] = rand_addr();
         issue_if.issue_c_i[1] = rand_addr();
         tick();
      end
      rst_ni = 1'b1;
      idle_cycles(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_issue_scheduler.md
Name: rf_issue_scheduler

Overview:
- Issue/write-back scheduler for the 32-bit register file with 4 write ports: arithmetic (ch0), logic (ch1), shift0 (ch2) and shift1 (ch3).
- Accepts one operation per channel through a valid/ready handshake and blocks RAW/WAW hazards using a per-register busy scoreboard.
- Counts each channel's fixed execution latency, then drives the register file write enable and write select for exactly one cycle.
- Sits between instruction decode and the register file: wb_en_o and wb_sel_o connect directly to the register file's enable_writing_i and select_r_i.

Parameters:
- ADDRESS_WIDTH, 5, register address width; UNITS = 2**ADDRESS_WIDTH; must be 3 or more.
- LAT0, 1, ch0 execution latency in cycles; legal range 1..15.
- LAT1, 1, ch1 latency; legal range 1..15.
- LAT2, 2, ch2 latency; legal range 1..15.
- LAT3, 2, ch3 latency; legal range 1..15.

Ports:
- clk_i  in  1  clock; everything updates on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- issue_valid_i  in  4  per-channel request.
- issue_ready_o  out  4  per-channel accept; a transfer occurs on valid&ready at the edge.
- issue_a_i  in  4xADDRESS_WIDTH  source A address per channel.
- issue_b_i  in  4xADDRESS_WIDTH  source B address per channel.
- issue_c_i  in  2xADDRESS_WIDTH  source C address, ch2/ch3 only (index 0 = ch2).
- issue_r_i  in  4xADDRESS_WIDTH  destination address per channel.
- issue_wr_i  in  4  the operation writes its destination.
- flush_i  in  1  abort all in-flight operations.
- wb_en_o  out  4  register file write enable per channel.
- wb_sel_o  out  4xADDRESS_WIDTH  register file write address per channel.
- busy_o  out  UNITS  scoreboard; bits 0..2 are always 0.
- illegal_dest_o  out  4  one-cycle pulse when an op with an illegal destination is accepted.
- idle_o  out  1  all channels idle and the scoreboard is empty.

Behaviour:
- Reset (rst_ni=0 at an edge):
  - all channels go to IDLE and all busy bits clear.
  - wb_en_o=0, wb_sel_o=0, illegal_dest_o=0, idle_o=1.
  - issue_ready_o=0 while rst_ni=0.
  - Reset mid-operation drops the op with no write-back.
- Per-channel FSM:
  - States: IDLE, EXEC(cnt), WB.
  - Accept with LATn=1: next state is WB.
  - Accept with LATn>1: next state is EXEC with cnt=LATn-1; cnt decrements each cycle; at cnt=1 the next state is WB.
  - WB lasts one cycle, then IDLE, or EXEC/WB again if a new op is accepted in the WB cycle.
- Latency: an op accepted at edge t has wb_en_o[n]=1 during exactly the cycle after edge t+LATn-1, i.e. LATn cycles after acceptance. wb_sel_o[n] holds the destination during that cycle.
- Readiness: issue_ready_o[n] = rst_ni & !flush_i & (state IDLE or WB) & no hazard. It is combinational from issue_*_i and the registered state.
- Hazard against registered busy state:
  - any used source (a, b; also c for ch2/ch3) with address 3 or more whose busy bit is set;
  - issue_wr_i set and the destination busy (WAW).
  - Addresses 0..2 (core input, instruction immediate, flags) never cause a hazard.
  - There is no bypass: a bit cleared by a write-back this cycle still blocks issue this cycle.
- Same-cycle priority: ch0 > ch1 > ch2 > ch3. A lower channel is also blocked if any of its sources, or its destination (when writing), equals the destination of a higher channel accepted in the same cycle. Two simultaneous write-backs to one address therefore cannot occur.
- Scoreboard:
  - On accept with wr and dest≥3, busy[dest] sets at that edge.
  - busy[dest] clears at the edge ending the WB cycle.
  - Set and clear of the same bit in the same edge is impossible by the WAW rule.
- Illegal destination: wr=1 with dest<3 is accepted and treated as wr=0. illegal_dest_o[n] pulses in the next cycle; there is no busy bit and no write-back.
- Non-writing ops (wr=0): the FSM still runs its latency, and wb_en_o stays 0 during WB.
- flush_i=1 at an edge:
  - all channels go to IDLE and all busy bits clear;
  - wb_en_o is forced to 0 in the flush cycle and nothing is accepted;
  - flush takes precedence over any same-cycle accept.
- idle_o is registered: 1 when all FSMs are IDLE and busy_o==0.

Test Plan:
- Reset, then ch0 accept with r=5, wr=1, LAT0=1 → busy_o[5]=1 the next cycle; wb_en_o[0]=1 with wb_sel_o[0]=5 for one cycle; busy_o[5]=0 after; idle_o=1.
- ch2 op with r=7 (LAT2=2), then ch0 op with a=7 one cycle later → issue_ready_o[0]=0 until the edge ending ch2's WB; ch0 is accepted the following cycle.
- ch0 and ch1 valid in the same cycle, both r=9 → only ch0 accepted; ch1 accepted once busy[9] clears; write-backs on ports 0 and 1 in distinct cycles.
- ch1 op with wr=1, r=2 → accepted; illegal_dest_o[1] pulses once; busy_o unchanged; wb_en_o[1] never asserted.
- ch2/ch3 in flight with r=4 and r=6, flush_i pulsed → busy_o=0 next cycle; no wb_en_o assertion ever follows; idle_o=1.
- rst_ni=0 asserted mid-EXEC on ch3 (r=10) → all outputs at reset values after the edge; no wb for r=10.
